// File: rtl/sync_down_seq_checker.sv
// Monitor for a modulo-2^CntW down counter: checks that each sampled value is the previous one
// minus one, tracks lock, and counts terminal-count wraps and step errors (both saturating).
module sync_down_seq_checker #(
    parameter int unsigned CntW  = 2,
    parameter int unsigned LockN = 4,
    parameter int unsigned ErrW  = 8,
    parameter int unsigned WrapW = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [CntW-1:0]  q_in_i,
    input  logic             err_clr_i,
    output logic             locked_o,
    output logic             tc_pulse_o,
    output logic [WrapW-1:0] wrap_count_o,
    output logic             err_flag_o,
    output logic [ErrW-1:0]  err_count_o,
    output logic [1:0]       state_o
);

    localparam int unsigned GoodW = 4;

    typedef enum logic [1:0] {
        StAcq   = 2'd0,
        StTrack = 2'd1,
        StLock  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   prev_q, prev_d;
    logic [GoodW-1:0]  good_q, good_d;
    logic              tc_q, tc_d;
    logic [WrapW-1:0]  wrap_q, wrap_d;
    logic              err_flag_q, err_flag_d;
    logic [ErrW-1:0]   err_cnt_q, err_cnt_d;

    logic [CntW-1:0]   expected;
    logic              good_step;
    logic              err_ev;

    assign expected  = prev_q - CntW'(1);
    assign good_step = (q_in_i == expected);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        good_d  = good_q;
        tc_d    = 1'b0;
        err_ev  = 1'b0;

        if (en_i) begin
            prev_d = q_in_i;
        end

        case (state_q)
            StAcq: begin
                if (en_i) begin
                    state_d = StTrack;
                    good_d  = '0;
                end
            end
            StTrack: begin
                if (en_i) begin
                    if (good_step) begin
                        good_d = good_q + GoodW'(1);
                        tc_d   = (q_in_i == '0);
                        if (good_q + GoodW'(1) == GoodW'(LockN)) begin
                            state_d = StLock;
                        end
                    end else begin
                        err_ev = 1'b1;
                        good_d = '0;
                    end
                end
            end
            StLock: begin
                if (en_i) begin
                    if (good_step) begin
                        tc_d = (q_in_i == '0);
                    end else begin
                        err_ev  = 1'b1;
                        good_d  = '0;
                        state_d = StTrack;
                    end
                end
            end
            default: begin
                // Unused encoding: fall back to acquisition without waiting for a sample.
                state_d = StAcq;
                good_d  = '0;
            end
        endcase
    end

    always_comb begin
        wrap_d = wrap_q;
        if (tc_d && (wrap_q != '1)) begin
            wrap_d = wrap_q + WrapW'(1);
        end

        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        // A clear coinciding with an error leaves exactly that one error recorded.
        if (err_clr_i) begin
            err_flag_d = err_ev;
            err_cnt_d  = err_ev ? ErrW'(1) : '0;
        end else if (err_ev) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ErrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StAcq;
            prev_q     <= '0;
            good_q     <= '0;
            tc_q       <= 1'b0;
            wrap_q     <= '0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            good_q     <= good_d;
            tc_q       <= tc_d;
            wrap_q     <= wrap_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign locked_o     = (state_q == StLock);
    assign tc_pulse_o   = tc_q;
    assign wrap_count_o = wrap_q;
    assign err_flag_o   = err_flag_q;
    assign err_count_o  = err_cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_sync_down_seq_checker.sv
// Bench for sync_down_seq_checker: directed vector table, hand-written corner sequences and
// randomized stimulus compared against a behavioural model.
module tb_sync_down_seq_checker;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] q_in;
    logic       err_clr;
    logic       locked;
    logic       tc_pulse;
    logic [7:0] wrap_count;
    logic       err_flag;
    logic [7:0] err_count;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: mode 0=acquire, 1=track, 2=lock
    int m_mode, m_prev, m_good, m_wrap, m_errc;
    bit m_tc, m_errf;

    sync_down_seq_checker #(
        .CntW  (2),
        .LockN (4),
        .ErrW  (8),
        .WrapW (8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .q_in_i       (q_in),
        .err_clr_i    (err_clr),
        .locked_o     (locked),
        .tc_pulse_o   (tc_pulse),
        .wrap_count_o (wrap_count),
        .err_flag_o   (err_flag),
        .err_count_o  (err_count),
        .state_o      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       en;
        bit [1:0] q;
        bit       clr;
        int       st;
        bit       lk;
        bit       tc;
        int       wrap;
        bit       ef;
        int       ec;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_good = 0; m_wrap = 0; m_errc = 0;
        m_tc = 0; m_errf = 0;
    endtask

    task automatic model_step(input bit e, input int q, input bit c);
        bit err_ev = 0;
        bit good;
        m_tc = 0;
        if (e) begin
            good = (q == (m_prev + 3) % 4);
            if (m_mode == 0) begin
                m_mode = 1;
                m_good = 0;
            end else if (good) begin
                m_tc = (q == 0);
                if (m_mode == 1) begin
                    m_good++;
                    if (m_good == 4) m_mode = 2;
                end
            end else begin
                err_ev = 1;
                m_good = 0;
                m_mode = 1;
            end
            m_prev = q;
        end
        if (c) begin
            m_errf = err_ev;
            m_errc = err_ev ? 1 : 0;
        end else if (err_ev) begin
            m_errf = 1;
            m_errc = (m_errc < 255) ? m_errc + 1 : 255;
        end
        if (m_tc) m_wrap = (m_wrap < 255) ? m_wrap + 1 : 255;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".state"}, int'(state), m_mode);
        chk({tag, ".locked"}, int'(locked), int'(m_mode == 2));
        chk({tag, ".tc"}, int'(tc_pulse), int'(m_tc));
        chk({tag, ".wrap"}, int'(wrap_count), m_wrap);
        chk({tag, ".eflag"}, int'(err_flag), int'(m_errf));
        chk({tag, ".ecount"}, int'(err_count), m_errc);
    endtask

    // Inputs are applied at negedge; outputs checked 1 time unit after the sampling edge.
    task automatic step(input bit e, input int q, input bit c, input string tag);
        en = e; q_in = q[1:0]; err_clr = c;
        @(posedge clk);
        model_step(e, q, c);
        #1;
        cmp_model(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        en = 0; q_in = 0; err_clr = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //          en q  clr  st lk tc wrap ef ec
        tbl[0]  = '{1, 0, 0,   1, 0, 0, 0,   0, 0};
        tbl[1]  = '{1, 3, 0,   1, 0, 0, 0,   0, 0};
        tbl[2]  = '{1, 2, 0,   1, 0, 0, 0,   0, 0};
        tbl[3]  = '{1, 1, 0,   1, 0, 0, 0,   0, 0};
        tbl[4]  = '{1, 0, 0,   2, 1, 1, 1,   0, 0};
        tbl[5]  = '{1, 3, 0,   2, 1, 0, 1,   0, 0};
        tbl[6]  = '{1, 2, 0,   2, 1, 0, 1,   0, 0};
        tbl[7]  = '{1, 1, 0,   2, 1, 0, 1,   0, 0};
        tbl[8]  = '{1, 0, 0,   2, 1, 1, 2,   0, 0};
        tbl[9]  = '{1, 1, 0,   1, 0, 0, 2,   1, 1};
        tbl[10] = '{1, 0, 0,   1, 0, 1, 3,   1, 1};
        tbl[11] = '{1, 3, 0,   1, 0, 0, 3,   1, 1};
        tbl[12] = '{1, 2, 0,   1, 0, 0, 3,   1, 1};
        tbl[13] = '{1, 1, 0,   2, 1, 0, 3,   1, 1};
        tbl[14] = '{1, 0, 0,   2, 1, 1, 4,   1, 1};
        tbl[15] = '{0, 2, 0,   2, 1, 0, 4,   1, 1};
        tbl[16] = '{0, 1, 0,   2, 1, 0, 4,   1, 1};
        tbl[17] = '{1, 3, 0,   2, 1, 0, 4,   1, 1};
        tbl[18] = '{1, 2, 1,   2, 1, 0, 4,   0, 0};

        rst_n = 1'b1; en = 0; q_in = 0; err_clr = 0;
        @(negedge clk);
        do_reset();
        #1;
        chk("rst.state", int'(state), 0);
        chk("rst.locked", int'(locked), 0);
        chk("rst.wrap", int'(wrap_count), 0);
        chk("rst.ecount", int'(err_count), 0);
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].en, tbl[i].q, tbl[i].clr, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.state", i), int'(state), tbl[i].st);
            chk($sformatf("tbl%0d.locked", i), int'(locked), int'(tbl[i].lk));
            chk($sformatf("tbl%0d.tc", i), int'(tc_pulse), int'(tbl[i].tc));
            chk($sformatf("tbl%0d.wrap", i), int'(wrap_count), tbl[i].wrap);
            chk($sformatf("tbl%0d.eflag", i), int'(err_flag), int'(tbl[i].ef));
            chk($sformatf("tbl%0d.ecount", i), int'(err_count), tbl[i].ec);
        end

        // 300 stall errors saturate the error counter; then clear collides with an error
        for (int i = 0; i < 300; i++) step(1, 2, 0, "sat");
        chk("sat.ecount255", int'(err_count), 255);
        step(1, 2, 1, "clrerr");
        chk("clrerr.ecount", int'(err_count), 1);
        chk("clrerr.eflag", int'(err_flag), 1);

        // Build err_count=5 and re-lock, then reset mid-cycle
        for (int i = 0; i < 4; i++) step(1, 2, 0, "e5");
        step(1, 1, 0, "rl"); step(1, 0, 0, "rl"); step(1, 3, 0, "rl"); step(1, 2, 0, "rl");
        chk("prerst.state", int'(state), 2);
        chk("prerst.ecount", int'(err_count), 5);
        en = 1; q_in = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("asyncrst.state", int'(state), 0);
        chk("asyncrst.locked", int'(locked), 0);
        chk("asyncrst.wrap", int'(wrap_count), 0);
        chk("asyncrst.eflag", int'(err_flag), 0);
        chk("asyncrst.ecount", int'(err_count), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, "reacq");
        chk("reacq.state", int'(state), 1);
        chk("reacq.tc", int'(tc_pulse), 0);

        // Upstream held at 00: every sample after the first is an error, no tc
        do_reset();
        step(1, 0, 0, "stall0");
        chk("stall0.tc", int'(tc_pulse), 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, "stall");
            chk("stall.tc", int'(tc_pulse), 0);
        end
        chk("stall.ecount", int'(err_count), 10);

        // Randomized stream: mostly correct steps, occasional jumps, gaps and clears
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit e;
            bit c;
            int q;
            e = ($urandom_range(0, 3) != 0);
            q = ($urandom_range(0, 9) < 8) ? (m_prev + 3) % 4 : int'($urandom_range(0, 3));
            c = e && ($urandom_range(0, 15) == 0);
            step(e, q, c, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
